// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between ShiftRows, this MixColumns stage and AddRoundKey.
// The slave view belongs to the MixColumns block, the master view to its environment.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_state, in_last, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_last, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// AES-128 MixColumns, applied column-serially (COLS_PER_CYCLE columns per clock)
// to a captured ShiftRows state; the final round passes the state through unchanged.
//
// state  | meaning
// IDLE   | ready for a new state, nothing held
// BUSY   | transforming columns in place, cnt selects the column group
// DONE   | result held on out_state until the downstream takes it
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int CPC = (COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) ? COLS_PER_CYCLE : 1;
  localparam int N   = 4 / CPC;
  localparam logic [1:0] CNT_LAST = 2'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         last_q, last_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 is the most significant byte of the column.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_state;
          last_d  = bus.in_last;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Final round: the selected columns are left as captured.
        for (int j = 0; j < 4; j++) begin
          if (2'(j / CPC) == cnt_q && !last_q) begin
            data_d[127 - 32*j -: 32] = mix_col(data_q[127 - 32*j -: 32]);
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_BUSY);
  assign bus.out_state = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: vector table plus handshake corner sequences on
// 1-, 2- and 4-column-per-cycle instances, results checked through scoreboards.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_columns_seq_if if1 ();
  mix_columns_seq_if if2 ();
  mix_columns_seq_if if4 ();

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [127:0] st;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_d4bf5d30;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_046681e5;
  localparam logic [127:0] C6 = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  vec_t         vecs[7];
  logic [127:0] sb1[$];
  logic [127:0] sb2[$];
  logic [127:0] sb4[$];
  logic [127:0] bv[3];
  logic [127:0] be[3];
  int           acc[3];
  int           idx;
  int           t;

  // Independent reference: generic GF(2^8) multiply and the MixColumns matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic last);
    logic [127:0] r = '0;
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [7:0]   m;
    if (last) return st;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = st[127 - 32*c - 8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = '0;
        for (int k = 0; k < 4; k++) begin
          m = (((k - rr) & 3) == 0) ? 8'd2 : ((((k - rr) & 3) == 1) ? 8'd3 : 8'd1);
          b = b ^ gmul(m, a[k]);
        end
        r[127 - 32*c - 8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      1: return if1.in_ready;
      2: return if2.in_ready;
      default: return if4.in_ready;
    endcase
  endfunction

  function automatic logic ovld(input int d);
    case (d)
      1: return if1.out_valid;
      2: return if2.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  task automatic drv(input int d, input logic v, input logic [127:0] s, input logic l);
    case (d)
      1: begin if1.in_valid = v; if1.in_state = s; if1.in_last = l; end
      2: begin if2.in_valid = v; if2.in_state = s; if2.in_last = l; end
      default: begin if4.in_valid = v; if4.in_state = s; if4.in_last = l; end
    endcase
  endtask

  // Returns 2 time units after the accept edge, with junk on the input bus.
  task automatic accept(input int d, input logic [127:0] s, input logic l);
    int tt = 0;
    @(negedge clk);
    while (!rdy(d) && tt < 50) begin
      @(negedge clk);
      tt++;
    end
    if (!rdy(d)) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout dut=%0d in_ready=0 required=1", d);
    end
    drv(d, 1'b1, s, l);
    @(posedge clk);
    #2;
    drv(d, 1'b0, {$urandom, $urandom, $urandom, $urandom}, ~l);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int d, input int exp_lat, input string name);
    int k = 0;
    @(negedge clk);
    while (!ovld(d) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, 160'(k), 160'(exp_lat));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (if1.out_valid && if1.out_ready) begin
        if (sb1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb1_unexpected: got %h expected none", if1.out_state);
        end else check("sb1_data", 160'(if1.out_state), 160'(sb1.pop_front()));
      end
      if (if2.out_valid && if2.out_ready) begin
        if (sb2.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb2_unexpected: got %h expected none", if2.out_state);
        end else check("sb2_data", 160'(if2.out_state), 160'(sb2.pop_front()));
      end
      if (if4.out_valid && if4.out_ready) begin
        if (sb4.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb4_unexpected: got %h expected none", if4.out_state);
        end else check("sb4_data", 160'(if4.out_state), 160'(sb4.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{V1, 1'b0, E1};
    vecs[1] = '{V1, 1'b1, V1};
    vecs[2] = '{C6, 1'b0, C6};
    vecs[3] = '{128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0,
                128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6};
    vecs[4] = '{128'h0, 1'b0, 128'h0};
    vecs[5].st = {$urandom, $urandom, $urandom, $urandom};
    vecs[5].last = 1'b0;
    vecs[5].exp = model(vecs[5].st, 1'b0);
    vecs[6].st = {$urandom, $urandom, $urandom, $urandom};
    vecs[6].last = 1'b1;
    vecs[6].exp = vecs[6].st;

    rst_n = 1'b0;
    drv(1, 1'b0, '0, 1'b0); drv(2, 1'b0, '0, 1'b0); drv(4, 1'b0, '0, 1'b0);
    if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
    #3;
    check("reset_u1", {if1.in_ready, if1.out_valid, if1.busy, if1.out_state}, {1'b1, 1'b0, 1'b0, 128'h0});
    check("reset_u2", {if2.in_ready, if2.out_valid, if2.busy, if2.out_state}, {1'b1, 1'b0, 1'b0, 128'h0});
    check("reset_u4", {if4.in_ready, if4.out_valid, if4.busy, if4.out_state}, {1'b1, 1'b0, 1'b0, 128'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on the one-column-per-cycle instance.
    for (int i = 0; i < 7; i++) begin
      sb1.push_back(vecs[i].exp);
      accept(1, vecs[i].st, vecs[i].last);
      wait_out(1, 4, $sformatf("latency_vec%0d", i));
    end

    // Backpressure in DONE.
    @(posedge clk); #2;
    if1.out_ready = 1'b0;
    sb1.push_back(E1);
    accept(1, V1, 1'b0);
    wait_out(1, 4, "latency_bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {if1.out_valid, if1.in_ready, if1.out_state},
            {1'b1, 1'b0, E1});
    end
    @(posedge clk); #2;
    if1.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {if1.in_ready, if1.out_valid}, {1'b1, 1'b0});

    // Reset after two BUSY edges discards the state.
    accept(1, V1, 1'b0);
    check("busy_after_accept", 160'(if1.busy), 160'(1));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midbusy", {if1.in_ready, if1.out_valid, if1.busy, if1.out_state},
          {1'b1, 1'b0, 1'b0, 128'h0});
    @(negedge clk);
    check("reset_hold_no_valid", {if1.out_valid, if1.out_state}, {1'b0, 128'h0});
    rst_n = 1'b1;
    sb1.push_back(E1);
    accept(1, V1, 1'b0);
    wait_out(1, 4, "latency_after_reset");

    // Back-to-back with in_valid held high.
    bv[0] = V1;         be[0] = E1;
    bv[1] = vecs[3].st; be[1] = vecs[3].exp;
    bv[2] = vecs[5].st; be[2] = vecs[5].exp;
    @(posedge clk); #2;
    idx = 0;
    t = 0;
    drv(1, 1'b1, bv[0], 1'b0);
    sb1.push_back(be[0]);
    while (idx < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (if1.in_ready) begin
        acc[idx] = cyc;
        @(posedge clk); #2;
        idx++;
        if (idx < 3) begin
          drv(1, 1'b1, bv[idx], 1'b0);
          sb1.push_back(be[idx]);
        end else begin
          drv(1, 1'b0, '0, 1'b0);
        end
      end
    end
    check("b2b_accepts", 160'(idx), 160'(3));
    check("b2b_spacing01", 160'(acc[1] - acc[0]), 160'(6));
    check("b2b_spacing12", 160'(acc[2] - acc[1]), 160'(6));
    t = 0;
    while (sb1.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("b2b_drained", 160'(sb1.size()), 160'(0));

    // Wider datapaths.
    sb4.push_back(C6);
    accept(4, C6, 1'b0);
    wait_out(4, 1, "latency_c4_c6");
    sb4.push_back(E1);
    accept(4, V1, 1'b0);
    wait_out(4, 1, "latency_c4_v1");
    sb2.push_back(E1);
    accept(2, V1, 1'b0);
    wait_out(2, 2, "latency_c2_v1");
    sb2.push_back(vecs[6].st);
    accept(2, vecs[6].st, 1'b1);
    wait_out(2, 2, "latency_c2_last");

    @(negedge clk);
    @(negedge clk);
    check("sb_all_drained", 160'(sb1.size() + sb2.size() + sb4.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
